// File: rtl/spi_master_fifo.sv
// SPI master with register port, TX/RX word FIFOs, programmable clock divider,
// all four SPI modes, selectable bit order and per-word latched transfer settings.
module spi_master_fifo #(
  parameter int DATABITS   = 8,
  parameter int NUMSLAVES  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_select,
  input  logic [2:0]           mem_addr,
  input  logic                 read_n,
  input  logic                 write_n,
  input  logic [15:0]          data_from_cpu,
  output logic [15:0]          data_to_cpu,
  output logic                 irq,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [NUMSLAVES-1:0] SS_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(2 * DATABITS);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATABITS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t state, next_state;

  logic rd_q, wr_q, rd_act, wr_act, rd_pulse, wr_pulse;
  logic [8:0] ctrl;
  logic [15:0] divider, div_eff, div_cnt;
  logic [NUMSLAVES-1:0] slave_sel, sel_l;
  logic roe, toe, tick;
  logic [5:0] status;
  logic [15:0] read_data;

  logic [DATABITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATABITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_drop, tx_pop;
  logic rx_pop_req, rx_pop, rx_push, rx_drop;
  logic [DATABITS-1:0] rx_pop_val, rx_hold;

  logic [EW-1:0] edge_cnt;
  logic sclk_q, cpol_l, cpha_l, lsb_l;
  logic [DATABITS-1:0] tx_shift, rx_shift, rx_next, rx_word;
  logic last_edge, word_done, word_start, sample, advance;

  // Each CPU access spans two cycles; only the first cycle of a strobe acts.
  assign rd_act   = spi_select && !read_n;
  assign wr_act   = spi_select && !write_n;
  assign rd_pulse = rd_act && !rd_q;
  assign wr_pulse = wr_act && !wr_q;

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_push_req = wr_pulse && (mem_addr == 3'd1);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop     = tx_push_req && tx_full;
  assign rx_pop_req  = rd_pulse && (mem_addr == 3'd0);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_pop_val  = rx_empty ? '0 : rx_mem[rx_rd];

  assign div_eff = (divider == 16'd0) ? 16'd1 : divider;
  assign tick    = (state != IDLE) && (div_cnt >= div_eff - 16'd1);

  // Even edges are leading edges; CPHA picks which edge samples and which shifts.
  assign last_edge  = (edge_cnt == LAST_EDGE);
  assign word_done  = (state == SHIFT) && tick && last_edge;
  assign word_start = ((state == IDLE) || word_done) && !tx_empty;
  assign tx_pop     = word_start;
  assign rx_push    = word_done && !rx_full;
  assign rx_drop    = word_done && rx_full;
  assign sample     = cpha_l ? edge_cnt[0] : !edge_cnt[0];
  assign advance    = cpha_l ? (!edge_cnt[0] && (edge_cnt != '0)) : (edge_cnt[0] && !last_edge);
  assign rx_next    = lsb_l ? {MISO, rx_shift[DATABITS-1:1]} : {rx_shift[DATABITS-2:0], MISO};
  assign rx_word    = sample ? rx_next : rx_shift;

  assign status = {state != IDLE, tx_empty && (state == IDLE), !tx_full, !rx_empty, toe, roe};

  assign SCLK = sclk_q;
  assign MOSI = (state == IDLE) ? 1'b0 : (lsb_l ? tx_shift[0] : tx_shift[DATABITS-1]);
  assign SS_n = ((state != IDLE) || ctrl[3]) ? ~sel_l : '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!tx_empty) next_state = SETUP;
      SETUP:   if (tick) next_state = SHIFT;
      SHIFT:   if (word_done) next_state = tx_empty ? HOLD : SHIFT;
      HOLD:    if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= data_from_cpu[DATABITS-1:0];
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // Word start overrides the shift updates so back-to-back words reload cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      sclk_q   <= 1'b0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      sel_l    <= NUMSLAVES'(1);
    end else begin
      div_cnt <= ((state == IDLE) || tick) ? 16'd0 : div_cnt + 16'd1;
      if (state == IDLE) sclk_q <= ctrl[0];
      if ((state == SHIFT) && tick) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_cnt + EW'(1);
        if (sample)  rx_shift <= rx_next;
        if (advance) tx_shift <= lsb_l ? (tx_shift >> 1) : (tx_shift << 1);
      end
      if (word_start) begin
        tx_shift <= tx_mem[tx_rd];
        rx_shift <= '0;
        edge_cnt <= '0;
        cpol_l   <= ctrl[0];
        cpha_l   <= ctrl[1];
        lsb_l    <= ctrl[2];
        sel_l    <= slave_sel;
        sclk_q   <= ctrl[0];
      end
    end
  end

  // RXDATA keeps the popped word visible for the whole two-cycle read.
  always_comb begin
    read_data = '0;
    case (mem_addr)
      3'd0:    read_data = 16'(rx_pop_req ? rx_pop_val : rx_hold);
      3'd2:    read_data = 16'(status);
      3'd3:    read_data = 16'(ctrl);
      3'd4:    read_data = divider;
      3'd5:    read_data = 16'(slave_sel);
      3'd6:    read_data = {8'(rx_count), 8'(tx_count)};
      default: read_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ctrl        <= '0;
      divider     <= 16'(DIV_RESET);
      slave_sel   <= NUMSLAVES'(1);
      roe         <= 1'b0;
      toe         <= 1'b0;
      rx_hold     <= '0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      rd_q <= rd_act;
      wr_q <= wr_act;
      if (wr_pulse) begin
        case (mem_addr)
          3'd3:    ctrl      <= data_from_cpu[8:0];
          3'd4:    divider   <= data_from_cpu;
          3'd5:    slave_sel <= data_from_cpu[NUMSLAVES-1:0];
          default: ;
        endcase
      end
      if (rx_drop) roe <= 1'b1;
      else if (wr_pulse && (mem_addr == 3'd2)) roe <= 1'b0;
      if (tx_drop) toe <= 1'b1;
      else if (wr_pulse && (mem_addr == 3'd2)) toe <= 1'b0;
      if (rx_pop_req) rx_hold <= rx_pop_val;
      data_to_cpu <= read_data;
      irq         <= |(status[4:0] & ctrl[8:4]);
    end
  end

endmodule

// File: doc/spi_master_fifo.md
SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

Interface
REQ-001 Parameter DATABITS, default 8, SPI word width in bits, legal 4..16.
REQ-002 Parameter NUMSLAVES, default 1, number of slave-select lines, legal 1..16.
REQ-003 Parameter FIFO_DEPTH, default 4, TX and RX FIFO depth in words, power of 2, legal 2..64.
REQ-004 Parameter DIV_RESET, default 6, reset value of the divider register.
REQ-005 clk  in  1  single system clock; all logic rises on posedge clk.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 spi_select  in  1  register-port chip select.
REQ-008 mem_addr  in  3  register address.
REQ-009 read_n / write_n  in  1 each  active-low read / write strobes.
REQ-010 data_from_cpu  in  16  write data.
REQ-011 data_to_cpu  out  16  registered read data.
REQ-012 irq  out  1  registered interrupt request.
REQ-013 SCLK, MOSI  out  1 each  SPI clock and serial data out.
REQ-014 MISO  in  1  serial data in.
REQ-015 SS_n  out  NUMSLAVES  active-low slave selects.

Function
REQ-016 Each register access lasts two clk cycles; the block acts only on the first cycle (edge-detected strobe); data_to_cpu is registered from mem_addr every cycle.
REQ-017 Map: 0 RXDATA r (pop), 1 TXDATA w (push), 2 STATUS r / write clears ROE and TOE, 3 CONTROL r/w, 4 DIVIDER r/w [15:0], 5 SLAVESEL r/w [NUMSLAVES-1:0], 6 LEVELS r ({rx_count[7:0], tx_count[7:0]}); unused read bits return 0.
REQ-018 STATUS bits: 0 ROE, 1 TOE, 2 RRDY (RX not empty), 3 TRDY (TX not full), 4 TMT (TX empty and state IDLE), 5 BUSY (state not IDLE).
REQ-019 CONTROL bits: 0 CPOL, 1 CPHA, 2 LSBFIRST, 3 SSO (force selects active), 4..8 interrupt enables for status bits 0..4.
REQ-020 irq = registered OR over status bits 0..4 AND their enables; one-cycle latency.
REQ-021 TX write when full: word dropped, TOE set; when not full: pushed, tx_count+1.
REQ-022 RXDATA read when empty: returns 0, no pointer change; otherwise returns head word zero-extended and pops.
REQ-023 Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance; pointers wrap modulo FIFO_DEPTH.
REQ-024 Half-period tick every max(DIVIDER,1) clk cycles while not IDLE; counter held at 0 in IDLE.
REQ-025 States: IDLE -> SETUP when TX not empty; SETUP (1 half-period, SS asserted, first bit on MOSI) -> SHIFT; SHIFT (2*DATABITS half-periods) -> TX not empty ? SHIFT (SS held) : HOLD; HOLD (1 half-period, SS asserted, SCLK idle) -> IDLE.
REQ-026 CPOL, CPHA, LSBFIRST, SLAVESEL latched at each TX pop (word start); writes during a word take effect on the next word.
REQ-027 SCLK idles at CPOL; toggles once per tick in SHIFT.
REQ-028 CPHA=0: sample MISO on leading edge, shift MOSI on trailing; CPHA=1: shift on leading, sample on trailing.
REQ-029 LSBFIRST=1: bit 0 out first and received bits enter at MSB shifting right; else MSB first, shifting left.
REQ-030 Word completion pushes received word to RX; if RX full, word discarded and ROE set.
REQ-031 SS_n = ~latched SLAVESEL when state is SETUP/SHIFT/HOLD or SSO=1; else all ones.
REQ-032 ROE/TOE set and STATUS-write clear on the same cycle: set wins.

Reset
REQ-033 reset_n low, any state: state IDLE, FIFOs empty, pointers 0, ROE/TOE 0, CONTROL 0, DIVIDER=DIV_RESET, SLAVESEL=1, SCLK=0, MOSI=0, SS_n all ones, data_to_cpu 0, irq 0; a word in flight is lost without RX push.

Verification
REQ-034 DATABITS=8, CPOL=0 CPHA=0 LSBFIRST=0, DIVIDER=2, push 0xA5, MISO looped to MOSI -> MOSI 1,0,1,0,0,1,0,1; 8 SCLK pulses of 2 clk high/2 low; RXDATA reads 0x00A5; SS_n[0] low for SETUP+16+HOLD half-periods.
REQ-035 Modes 1-3 with LSBFIRST=1, push 0x3C loopback -> MOSI 0,0,1,1,1,1,0,0; SCLK idle level = CPOL; RXDATA 0x003C each mode.
REQ-036 FIFO_DEPTH=4, push 6 words while DIVIDER=100 -> LEVELS tx_count saturates at 4 (one possibly popped), TOE=1, irq=1 with enable bit 5 set; STATUS write clears TOE.
REQ-037 Push 5 words with no RX reads -> 4 words retained in RX, 5th discarded, ROE=1; SS_n stays low across back-to-back words.
REQ-038 Assert reset_n low mid-SHIFT -> SS_n all ones, SCLK=0, LEVELS 0, BUSY=0 immediately (asynchronous).
